// File: rtl/fsm_stream_decoder.sv
// fsm_stream_decoder
//   Sink-side receiver for the 2-bit state-code stream of the 4-state safe
//   sequence generator (S0=01, S1=10, S2=11, S3=00). It shadows the generator
//   state, recovers the data bit behind each legal transition, packs the bits
//   into WORD_W-bit words (first bit in MSB) and flags illegal transitions.
// Ports:
//   clk, reset           rising-edge clock, async active-high reset
//   code_in, code_en     code stream and its sample enable
//   err_clr              synchronous clear of err_count (wins over increment)
//   bit_out, bit_valid   recovered bit + one-cycle strobe
//   word_out, word_valid assembled word + one-cycle strobe
//   locked               high while tracking the generator
//   err, err_count       illegal-transition strobe (locked only) + sat. count
module fsm_stream_decoder #(
  parameter int WORD_W   = 8,
  parameter int LOCK_RUN = 4,
  parameter int ERR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        code_in,
  input  logic              code_en,
  input  logic              err_clr,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t              r_state, w_state_n;
  logic [1:0]          r_prev, w_prev_n;
  logic [3:0]          r_run, w_run_n;
  logic [CNT_W-1:0]    r_bcnt, w_bcnt_n;
  logic [WORD_W-1:0]   r_shift, w_shift_n;
  logic                r_bit_out, w_bit_out_n;
  logic                r_bit_valid, w_bit_valid_n;
  logic [WORD_W-1:0]   r_word_out, w_word_out_n;
  logic                r_word_valid, w_word_valid_n;
  logic                r_err, w_err_n;
  logic [ERR_W-1:0]    r_err_cnt, w_err_cnt_n;

  // Transition decode of (r_prev -> code_in)
  logic       w_restart, w_legal, w_has_bit, w_bit;
  logic [3:0] w_run_inc;

  always_comb begin
    w_restart = (code_in == 2'b01);
    w_legal   = 1'b0;
    w_has_bit = 1'b0;
    w_bit     = 1'b0;
    if (!w_restart) begin
      case (r_prev)
        2'b01: w_legal = (code_in == 2'b10);
        2'b10: begin
          w_legal   = (code_in == 2'b10) || (code_in == 2'b11);
          w_has_bit = w_legal;
          w_bit     = (code_in == 2'b11);
        end
        2'b11: begin
          w_legal   = (code_in == 2'b10) || (code_in == 2'b00);
          w_has_bit = w_legal;
          w_bit     = (code_in == 2'b00);
        end
        default: begin // 2'b00
          w_legal   = (code_in == 2'b00) || (code_in == 2'b11);
          w_has_bit = w_legal;
          w_bit     = (code_in == 2'b11);
        end
      endcase
    end
  end

  assign w_run_inc = r_run + 4'd1;

  always_comb begin
    w_state_n      = r_state;
    w_prev_n       = r_prev;
    w_run_n        = r_run;
    w_bcnt_n       = r_bcnt;
    w_shift_n      = r_shift;
    w_bit_out_n    = r_bit_out;
    w_bit_valid_n  = 1'b0;
    w_word_out_n   = r_word_out;
    w_word_valid_n = 1'b0;
    w_err_n        = 1'b0;
    w_err_cnt_n    = r_err_cnt;
    if (code_en) begin
      w_prev_n = code_in;
      case (r_state)
        HUNT: begin
          // Keep the assembly path empty so LOCKED always starts on a fresh word.
          w_bcnt_n  = '0;
          w_shift_n = '0;
          if (w_restart) begin
            w_state_n = LOCKED;
            w_run_n   = '0;
          end else if (w_legal) begin
            if (w_run_inc == 4'(LOCK_RUN)) begin
              w_state_n = LOCKED;
              w_run_n   = '0;
            end else begin
              w_run_n = w_run_inc;
            end
          end else begin
            w_run_n = '0;
          end
        end
        default: begin // LOCKED
          if (w_restart) begin
            w_bcnt_n  = '0;
            w_shift_n = '0;
          end else if (w_has_bit) begin
            w_bit_valid_n = 1'b1;
            w_bit_out_n   = w_bit;
            w_shift_n     = {r_shift[WORD_W-2:0], w_bit};
            if (r_bcnt == CNT_W'(WORD_W - 1)) begin
              w_word_out_n   = w_shift_n;
              w_word_valid_n = 1'b1;
              w_bcnt_n       = '0;
            end else begin
              w_bcnt_n = r_bcnt + 1'b1;
            end
          end else if (!w_legal) begin
            w_err_n   = 1'b1;
            w_state_n = HUNT;
            w_run_n   = '0;
            w_bcnt_n  = '0;
            w_shift_n = '0;
            if (r_err_cnt != '1) w_err_cnt_n = r_err_cnt + 1'b1;
          end
          // legal 01->10 carries no bit: nothing to do
        end
      endcase
    end
    if (err_clr) w_err_cnt_n = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= HUNT;
      r_prev       <= 2'b01;
      r_run        <= '0;
      r_bcnt       <= '0;
      r_shift      <= '0;
      r_bit_out    <= 1'b0;
      r_bit_valid  <= 1'b0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_state      <= w_state_n;
      r_prev       <= w_prev_n;
      r_run        <= w_run_n;
      r_bcnt       <= w_bcnt_n;
      r_shift      <= w_shift_n;
      r_bit_out    <= w_bit_out_n;
      r_bit_valid  <= w_bit_valid_n;
      r_word_out   <= w_word_out_n;
      r_word_valid <= w_word_valid_n;
      r_err        <= w_err_n;
      r_err_cnt    <= w_err_cnt_n;
    end
  end

  assign bit_out    = r_bit_out;
  assign bit_valid  = r_bit_valid;
  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign locked     = (r_state == LOCKED);
  assign err        = r_err;
  assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_fsm_stream_decoder.sv
// Scoreboard bench: stimulus pushes expected bits/words/err-counts into
// queues; a negedge monitor pops and compares whenever a strobe appears.
module tb_fsm_stream_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] code_in = 2'b01;
  logic       code_en = 1'b0;
  logic       err_clr = 1'b0;
  logic       bit_out, bit_valid, word_valid, locked, err;
  logic [7:0] word_out, err_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic       q_bit[$];
  logic [7:0] q_word[$];
  logic [7:0] q_err[$];

  fsm_stream_decoder #(.WORD_W(8), .LOCK_RUN(4), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .code_en(code_en),
    .err_clr(err_clr), .bit_out(bit_out), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid), .locked(locked),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each strobe against the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bit_valid) begin
        if (q_bit.size() == 0) chk("unexpected bit_valid", 1, 0);
        else chk("bit_out", {31'd0, bit_out}, {31'd0, q_bit.pop_front()});
      end
      if (word_valid) begin
        if (q_word.size() == 0) chk("unexpected word_valid", 1, 0);
        else chk("word_out", {24'd0, word_out}, {24'd0, q_word.pop_front()});
      end
      if (err) begin
        if (q_err.size() == 0) chk("unexpected err", 1, 0);
        else chk("err_count at err", {24'd0, err_count}, {24'd0, q_err.pop_front()});
      end
    end
  end

  task automatic send(input logic [1:0] c);
    code_in = c;
    code_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    code_en = 1'b0;
    @(posedge clk);
    #1;
    chk("no strobe when code_en=0", {29'd0, bit_valid, word_valid, err}, 0);
  endtask

  task automatic push_bits(input logic [7:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) q_bit.push_back(b[i]);
  endtask

  task automatic push_err();
    exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
    q_err.push_back(8'(exp_cnt));
  endtask

  logic [1:0] s1[10] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("reset outputs", {20'd0, bit_out, bit_valid, word_valid, locked, err, 7'd0}, 0);
    chk("reset word_out", {24'd0, word_out}, 0);
    chk("reset err_count", {24'd0, err_count}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic locked stream -> D3
    push_bits(8'hD3, 8);
    q_word.push_back(8'hD3);
    send(2'b01);
    chk("locked after 01", {31'd0, locked}, 1);
    for (int i = 1; i < 10; i++) send(s1[i]);

    // prev=00 -> 11(1),10(0), then illegal 10->00
    push_bits(8'b10, 2);
    send(2'b11);
    send(2'b10);
    push_err();
    send(2'b00);
    chk("locked dropped on err", {31'd0, locked}, 0);
    chk("err_count after err", {24'd0, err_count}, 1);

    // Unlocked start: first pair 00->10 illegal, then 4 legal -> lock
    send(2'b10);
    send(2'b10);
    send(2'b11);
    send(2'b10);
    chk("not locked after 4th", {31'd0, locked}, 0);
    send(2'b10);
    chk("locked after 5th", {31'd0, locked}, 1);
    // 1 then 0,1,1,0,1,0,1 -> B5 (discarded partial bits must not appear)
    push_bits(8'hB5, 8);
    q_word.push_back(8'hB5);
    send(2'b11);
    send(2'b10); send(2'b11); send(2'b00); send(2'b00);
    send(2'b11); send(2'b10); send(2'b11);

    // 5 bits, restart, then a fresh full word 9E
    push_bits(8'b01101, 5);
    send(2'b10); send(2'b11); send(2'b00); send(2'b00); send(2'b11);
    send(2'b01);
    chk("locked after restart", {31'd0, locked}, 1);
    send(2'b10);
    push_bits(8'h9E, 8);
    q_word.push_back(8'h9E);
    send(2'b11); send(2'b10); send(2'b10); send(2'b11);
    send(2'b00); send(2'b11); send(2'b00); send(2'b00);
    chk("err_count unchanged", {24'd0, err_count}, 1);

    // code_en toggled: same result as uninterrupted stream
    push_bits(8'hD3, 8);
    q_word.push_back(8'hD3);
    for (int i = 0; i < 10; i++) begin
      send(s1[i]);
      idle();
    end

    // Saturation: 300 errors with relock between each
    for (int i = 0; i < 300; i++) begin
      send(2'b01);
      push_err();
      send(2'b00);
    end
    chk("err_count saturated", {24'd0, err_count}, 32'hFF);
    send(2'b01);
    err_clr = 1'b1;
    exp_cnt = 0;
    q_err.push_back(8'd0);
    send(2'b00);
    err_clr = 1'b0;
    chk("err_count cleared", {24'd0, err_count}, 0);

    // Reset mid-word
    send(2'b01);
    push_bits(8'b110, 3);
    send(2'b10); send(2'b11); send(2'b00); send(2'b00);
    code_en = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset outputs", {26'd0, bit_out, bit_valid, word_valid, locked, err}, 0);
    chk("async reset err_count", {24'd0, err_count}, 0);
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    push_bits(8'hD3, 8);
    q_word.push_back(8'hD3);
    for (int i = 0; i < 10; i++) send(s1[i]);

    idle();
    idle();
    chk("bits drained", q_bit.size(), 0);
    chk("words drained", q_word.size(), 0);
    chk("errs drained", q_err.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
